// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared definitions for the AHB response mux and its default slave.
//  - HTRANS_* / HRESP_* encodings used on the bus
//  - dsel one-hot encoding: bits 0..3 are slaves 0..3, bit 4 is the default slave
//  - dflt_state_t: state of the default slave's two-cycle ERROR response
//  - decode_sel / is_active helpers for the address-phase capture
// Optional feature macro used by the design: AHB_DEFAULT_SLV_EN
package ahb_pkg;

    localparam int NUM_SLV = 4;
    localparam int DSEL_W  = NUM_SLV + 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [DSEL_W-1:0] DSEL_S0      = 5'b00001;
    localparam logic [DSEL_W-1:0] DSEL_S1      = 5'b00010;
    localparam logic [DSEL_W-1:0] DSEL_S2      = 5'b00100;
    localparam logic [DSEL_W-1:0] DSEL_S3      = 5'b01000;
    localparam logic [DSEL_W-1:0] DSEL_DEFAULT = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } dflt_state_t;

    // Exactly one select high picks that slave; none or several falls to the
    // default slave so overlapping decodes can never OR slave data together.
    function automatic logic [DSEL_W-1:0] decode_sel(input logic [NUM_SLV-1:0] hsel);
        logic [DSEL_W-1:0] result;
        result = DSEL_DEFAULT;
        if ($onehot(hsel)) begin
            result = {1'b0, hsel};
        end
        return result;
    endfunction

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
    function automatic logic is_active(input logic [1:0] htrans);
        logic result;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: result = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  result = 1'b0;
            default:                   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave
// Two-cycle ERROR responder for data phases that hit no (or an ambiguous) slave.
// Ports:
//  hclk          in   bus clock
//  hreset        in   synchronous active-high reset
//  hready        in   global hready (address phase completes when high)
//  addr_dflt_act in   address phase being captured is default-selected and active
//  dflt_hready   out  hready contribution while an active default phase is in progress
//  dflt_hresp    out  hresp contribution while an active default phase is in progress
// Only instantiated by the top when AHB_DEFAULT_SLV_EN is defined.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hready,
    input  logic       addr_dflt_act,
    output logic       dflt_hready,
    output logic [1:0] dflt_hresp
);

    dflt_state_t state_q;
    dflt_state_t state_d;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The FSM enters ERR1 on the same edge the top captures a default+active
    // address phase, so the very first data-phase cycle already stalls.
    // ERR1 stalls with ERROR, ERR2 completes with ERROR; ERR2 may chain
    // straight into another ERR1 for back-to-back unmapped transfers.
    always_comb begin
        state_d     = state_q;
        dflt_hready = 1'b1;
        dflt_hresp  = HRESP_OKAY;
        case (state_q)
            IDLE: begin
                if (hready && addr_dflt_act) begin
                    state_d = ERR1;
                end
            end
            ERR1: begin
                dflt_hready = 1'b0;
                dflt_hresp  = HRESP_ERROR;
                state_d     = ERR2;
            end
            ERR2: begin
                dflt_hresp = HRESP_ERROR;
                if (hready && addr_dflt_act) begin
                    state_d = ERR1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux
// Slave-to-master response mux of the AHB interconnect. Registers the decoded
// slave select at the end of each address phase and routes that slave's
// hrdata/hreadyout/hresp to the master during the data phase.
// Ports:
//  hclk, hreset             clock, synchronous active-high reset
//  hsel0..3                 address-phase selects from the decoder
//  htrans                   master transfer type
//  hrdata0..3               slave read data
//  hreadyout0..3            slave ready
//  hresp0..3                slave response
//  hrdata, hready, hresp    response to the master (hready also goes to all slaves)
// Macro AHB_DEFAULT_SLV_EN: when defined, unmapped active transfers get a
// two-cycle ERROR response; otherwise they complete zero-wait with OKAY.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel0,
    input  logic              hsel1,
    input  logic              hsel2,
    input  logic              hsel3,
    input  logic [1:0]        htrans,
    input  logic [DATA_W-1:0] hrdata0,
    input  logic [DATA_W-1:0] hrdata1,
    input  logic [DATA_W-1:0] hrdata2,
    input  logic [DATA_W-1:0] hrdata3,
    input  logic              hreadyout0,
    input  logic              hreadyout1,
    input  logic              hreadyout2,
    input  logic              hreadyout3,
    input  logic [1:0]        hresp0,
    input  logic [1:0]        hresp1,
    input  logic [1:0]        hresp2,
    input  logic [1:0]        hresp3,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic [1:0]        hresp
);

    logic [DSEL_W-1:0] dsel;
    logic              d_active;
    logic [DSEL_W-1:0] addr_dsel;
    logic              addr_active;
    logic              dflt_hready;
    logic [1:0]        dflt_hresp;

    assign addr_dsel   = decode_sel({hsel3, hsel2, hsel1, hsel0});
    assign addr_active = is_active(htrans);

    // Address phase ends only when hready is high; during a stall the data
    // phase is frozen and any change on hsel/htrans is ignored.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            dsel     <= DSEL_DEFAULT;
            d_active <= 1'b0;
        end else if (hready) begin
            dsel     <= addr_dsel;
            d_active <= addr_active;
        end
    end

`ifdef AHB_DEFAULT_SLV_EN
    ahb_default_slave u_default_slave (
        .hclk          (hclk),
        .hreset        (hreset),
        .hready        (hready),
        .addr_dflt_act ((addr_dsel == DSEL_DEFAULT) && addr_active),
        .dflt_hready   (dflt_hready),
        .dflt_hresp    (dflt_hresp)
    );
`else
    // Without the error responder every default data phase is zero-wait OKAY.
    assign dflt_hready = 1'b1;
    assign dflt_hresp  = HRESP_OKAY;
`endif

    // Data-phase mux straight from the registered select: no extra latency on
    // the ready/data path. An idle default phase always completes zero-wait;
    // an active one takes whatever the default slave responds.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (dsel)
            DSEL_S0: begin
                hrdata = hrdata0;
                hready = hreadyout0;
                hresp  = hresp0;
            end
            DSEL_S1: begin
                hrdata = hrdata1;
                hready = hreadyout1;
                hresp  = hresp1;
            end
            DSEL_S2: begin
                hrdata = hrdata2;
                hready = hreadyout2;
                hresp  = hresp2;
            end
            DSEL_S3: begin
                hrdata = hrdata3;
                hready = hreadyout3;
                hresp  = hresp3;
            end
            DSEL_DEFAULT: begin
                if (d_active) begin
                    hready = dflt_hready;
                    hresp  = dflt_hresp;
                end
            end
            default: begin
                hrdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux
// Self-checking bench for ahb_resp_mux: a directed table of per-cycle vectors
// with constant expectations, followed by randomized traffic compared against
// a transaction-level reference model (current data-phase target, whether it
// is active, and which cycle of the error response is being served).
// Follows AHB_DEFAULT_SLV_EN the same way the design does.
module tb_ahb_resp_mux;

`ifdef AHB_DEFAULT_SLV_EN
    localparam bit DFLT_EN = 1'b1;
`else
    localparam bit DFLT_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hreset;
    logic [3:0]  ssel;
    logic [1:0]  htrans;
    logic [31:0] sdata [4];
    logic [3:0]  srdy;
    logic [1:0]  sresp [4];
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    int passed = 0;
    int total  = 0;

    always #5 hclk = ~hclk;

    ahb_resp_mux #(.DATA_W(32)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .hsel0      (ssel[0]),
        .hsel1      (ssel[1]),
        .hsel2      (ssel[2]),
        .hsel3      (ssel[3]),
        .htrans     (htrans),
        .hrdata0    (sdata[0]),
        .hrdata1    (sdata[1]),
        .hrdata2    (sdata[2]),
        .hrdata3    (sdata[3]),
        .hreadyout0 (srdy[0]),
        .hreadyout1 (srdy[1]),
        .hreadyout2 (srdy[2]),
        .hreadyout3 (srdy[3]),
        .hresp0     (sresp[0]),
        .hresp1     (sresp[1]),
        .hresp2     (sresp[2]),
        .hresp3     (sresp[3]),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp)
    );

    // Reference model: which slave the current data phase belongs to (-1 for
    // the default slave), whether it carries a transfer, and which cycle of
    // the ERROR response is being served (0 none, 1 first, 2 second).
    int m_sel = -1;
    bit m_act = 1'b0;
    int m_err = 0;

    function automatic void model_out(output logic e_rdy, output logic [1:0] e_resp,
                                      output logic [31:0] e_data);
        if (m_sel >= 0) begin
            e_rdy  = srdy[m_sel];
            e_resp = sresp[m_sel];
            e_data = sdata[m_sel];
        end else begin
            e_data = 32'h0;
            e_rdy  = (m_err != 1);
            e_resp = (m_err != 0) ? 2'b01 : 2'b00;
        end
    endfunction

    task automatic model_step();
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        model_out(e_rdy, e_resp, e_data);
        if (hreset) begin
            m_sel = -1;
            m_act = 1'b0;
            m_err = 0;
        end else if (e_rdy) begin
            m_sel = -1;
            if ($countones(ssel) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (ssel[i]) m_sel = i;
                end
            end
            m_act = (htrans == 2'b10) || (htrans == 2'b11);
            m_err = (DFLT_EN && m_sel < 0 && m_act) ? 1 : 0;
        end else if (m_err == 1) begin
            m_err = 2;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic [3:0] sel,
                                  input logic [1:0] trans, input logic [3:0] rdy);
        hreset = rst;
        ssel   = sel;
        htrans = trans;
        srdy   = rdy;
    endtask

    // Finish the current cycle: let the edge happen, update the model, and
    // move inputs away from the edge.
    task automatic end_cycle();
        @(posedge hclk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  sel;
        logic [1:0]  trans;
        logic [3:0]  rdy;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] sel, input logic [1:0] trans,
                                input logic [3:0] rdy, input logic e_rdy, input logic [1:0] e_resp,
                                input logic [31:0] e_data, input string name);
        vec_t v;
        v.rst = rst; v.sel = sel; v.trans = trans; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_data = e_data; v.name = name;
        return v;
    endfunction

    vec_t vecs [14];

    initial begin
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        int          r;

        // Directed table; each row's expectation is what the master sees
        // during that row's cycle. Unmapped active phases depend on the build.
        vecs[0]  = mk(0, 4'b0010, 2'b10, 4'b1111, 1, 2'b00, 32'h0,         "idle_default");
        vecs[1]  = mk(0, 4'b0100, 2'b10, 4'b1111, 1, 2'b00, 32'hA5A5_0001, "slv1_read");
        vecs[2]  = mk(0, 4'b0001, 2'b10, 4'b1011, 0, 2'b00, 32'h2222_0002, "slv2_wait1");
        vecs[3]  = mk(0, 4'b0001, 2'b10, 4'b1011, 0, 2'b00, 32'h2222_0002, "slv2_wait2");
        vecs[4]  = mk(0, 4'b0001, 2'b10, 4'b1111, 1, 2'b00, 32'h2222_0002, "slv2_done");
        vecs[5]  = mk(0, 4'b1000, 2'b10, 4'b1111, 1, 2'b00, 32'h0000_0001, "slv0_read");
        vecs[6]  = mk(0, 4'b0000, 2'b01, 4'b1111, 1, 2'b01, 32'h0000_0003, "slv3_read");
        vecs[7]  = mk(0, 4'b0000, 2'b10, 4'b1111, 1, 2'b00, 32'h0,         "busy_default");
        vecs[8]  = mk(0, 4'b0000, 2'b00, 4'b1111, !DFLT_EN, DFLT_EN ? 2'b01 : 2'b00, 32'h0, "dflt_cycle1");
        vecs[9]  = mk(0, 4'b0000, 2'b11, 4'b1111, 1,        DFLT_EN ? 2'b01 : 2'b00, 32'h0, "dflt_cycle2");
        vecs[10] = mk(0, 4'b0101, 2'b10, 4'b1111, !DFLT_EN, DFLT_EN ? 2'b01 : 2'b00, 32'h0, "chain_cycle1");
        vecs[11] = mk(0, 4'b0101, 2'b10, 4'b1111, 1,        DFLT_EN ? 2'b01 : 2'b00, 32'h0, "chain_cycle2");
        vecs[12] = mk(1, 4'b0000, 2'b00, 4'b1111, !DFLT_EN, DFLT_EN ? 2'b01 : 2'b00, 32'h0, "multi_cycle1_reset");
        vecs[13] = mk(0, 4'b0000, 2'b00, 4'b1111, 1, 2'b00, 32'h0,         "after_reset");

        // Reset for two cycles with slaves driving garbage and every select high.
        for (int i = 0; i < 4; i++) begin
            sdata[i] = 32'hDEAD_0000 | i;
            sresp[i] = 2'b11;
        end
        apply_stimulus(1'b1, 4'b1111, 2'b10, 4'b0000);
        #1;
        end_cycle();
        @(negedge hclk);
        check_output("reset_hready", {31'h0, hready}, 32'h1);
        check_output("reset_hresp",  {30'h0, hresp},  32'h0);
        check_output("reset_hrdata", hrdata,          32'h0);
        end_cycle();
        apply_stimulus(1'b0, 4'b0000, 2'b00, 4'b0000);
        @(negedge hclk);
        check_output("post_reset_hready", {31'h0, hready}, 32'h1);
        check_output("post_reset_hresp",  {30'h0, hresp},  32'h0);
        check_output("post_reset_hrdata", hrdata,          32'h0);
        end_cycle();

        // Directed table with fixed slave data; slave 3 answers ERROR.
        sdata[0] = 32'h0000_0001;
        sdata[1] = 32'hA5A5_0001;
        sdata[2] = 32'h2222_0002;
        sdata[3] = 32'h0000_0003;
        sresp[0] = 2'b00;
        sresp[1] = 2'b00;
        sresp[2] = 2'b00;
        sresp[3] = 2'b01;
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].sel, vecs[i].trans, vecs[i].rdy);
            @(negedge hclk);
            check_output({vecs[i].name, "_hready"}, {31'h0, hready}, {31'h0, vecs[i].e_rdy});
            check_output({vecs[i].name, "_hresp"},  {30'h0, hresp},  {30'h0, vecs[i].e_resp});
            check_output({vecs[i].name, "_hrdata"}, hrdata,          vecs[i].e_data);
            end_cycle();
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 500; c++) begin
            logic [3:0] sel;
            logic [3:0] rdy;
            r = $urandom_range(0, 9);
            if (r < 6)       sel = 4'b0001 << $urandom_range(0, 3);
            else if (r < 8)  sel = 4'b0000;
            else             sel = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                rdy[i]   = ($urandom_range(0, 3) != 0);
                sdata[i] = $urandom;
                sresp[i] = {1'b0, 1'($urandom_range(0, 1))};
            end
            apply_stimulus($urandom_range(0, 39) == 0, sel, 2'($urandom_range(0, 3)), rdy);
            @(negedge hclk);
            model_out(e_rdy, e_resp, e_data);
            check_output("rand_hready", {31'h0, hready}, {31'h0, e_rdy});
            check_output("rand_hresp",  {30'h0, hresp},  {30'h0, e_resp});
            check_output("rand_hrdata", hrdata,          e_data);
            end_cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
